// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial BCD adder and its digit slice.
package bcd_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  // True when a 4-bit code is not a legal BCD digit
  function automatic logic bcd_invalid(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_serial_adder_digit_add.sv
// Single-digit BCD adder: binary add, >9 detect and +6 correction (mod 16).
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  logic [DIGIT_W:0] s5_s;
  logic             gt9_s;

  // Illegal input codes still go through the same rule, so the 5-bit sum can reach 31
  always_comb begin
    s5_s  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
    gt9_s = (s5_s > (DIGIT_W + 1)'(BCD_MAX));
    if (gt9_s) begin
      s = s5_s[DIGIT_W-1:0] + DIGIT_W'(BCD_CORR);
    end else begin
      s = s5_s[DIGIT_W-1:0];
    end
    co = gt9_s;
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder that reuses one digit slice, least-significant digit first.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      err
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state_r, state_next_s;
  logic [W-1:0]       op_a_r, op_b_r, sum_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r, cout_r, err_r, busy_r, done_r;
  logic [DIGIT_W-1:0] dig_s;
  logic               dig_co_s;
  logic               err_s;
  logic               last_s;

  // Operands are shifted right each digit, so the current digit is always at the bottom
  bcd_digit_add u_digit (
    .a  (op_a_r[DIGIT_W-1:0]),
    .b  (op_b_r[DIGIT_W-1:0]),
    .ci (carry_r),
    .s  (dig_s),
    .co (dig_co_s)
  );

  assign last_s = (idx_r == LAST_IDX);

  // Flag any non-BCD digit in either operand at acceptance
  always_comb begin
    err_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      err_s = err_s | bcd_invalid(a[i*DIGIT_W +: DIGIT_W]) | bcd_invalid(b[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ADD;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADD: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ADD;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, status flags and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      op_a_r  <= '0;
      op_b_r  <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ADD);
      done_r  <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            op_a_r  <= a;
            op_b_r  <= b;
            carry_r <= cin;
            sum_r   <= '0;
            idx_r   <= '0;
            cout_r  <= 1'b0;
            err_r   <= err_s;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
              sum_r[i*DIGIT_W +: DIGIT_W] <= dig_s;
            end
          end
          op_a_r  <= op_a_r >> DIGIT_W;
          op_b_r  <= op_b_r >> DIGIT_W;
          carry_r <= dig_co_s;
          if (last_s) begin
            cout_r <= dig_co_s;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign err  = err_r;

endmodule
